// File: rtl/user_wb_window_pkg.sv
// Shared types and constants for the Wishbone window splitter.
package user_wb_window_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SLV  = 2'd1,
        ST_DBG  = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;
    localparam int          MAX_SLV  = 8;
    localparam int          MAX_DBG  = 8;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/user_dbg_reg_bank.sv
// Debug register bank: DBG_REGS x 32-bit words, byte-lane writes, combinational read.
module user_dbg_reg_bank #(
    parameter int DBG_REGS = 2,
    parameter int ADDR_W   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [3:0]            sel,
    input  logic [31:0]           wdat,
    output logic [31:0]           rdat,
    output logic [32*DBG_REGS-1:0] regs_o
);

    logic [31:0] regs [DBG_REGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DBG_REGS; i++) regs[i] <= '0;
        end else if (we) begin
            for (int i = 0; i < DBG_REGS; i++) begin
                if (32'(addr) == i) begin
                    for (int b = 0; b < 4; b++) begin
                        if (sel[b]) regs[i][8*b +: 8] <= wdat[8*b +: 8];
                    end
                end
            end
        end
    end

    always_comb begin
        rdat   = '0;
        regs_o = '0;
        for (int i = 0; i < DBG_REGS; i++) begin
            regs_o[32*i +: 32] = regs[i];
            if (32'(addr) == i) rdat = regs[i];
        end
    end

endmodule

// File: rtl/user_wb_window_mux.sv
// Splits the user Wishbone span into N_SLV slave windows plus a debug bank at the top,
// with registered responses, a per-access timeout and an error counter.
module user_wb_window_mux
    import user_wb_window_pkg::*;
#(
    parameter int N_SLV     = 2,
    parameter int SPAN_BITS = 20,
    parameter int DBG_REGS  = 2,
    parameter int TIMEOUT   = 255
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    input  logic                    wbs_cyc_i,
    input  logic                    wbs_stb_i,
    input  logic                    wbs_we_i,
    input  logic [3:0]              wbs_sel_i,
    input  logic [31:0]             wbs_adr_i,
    input  logic [31:0]             wbs_dat_i,
    output logic                    wbs_ack_o,
    output logic [31:0]             wbs_dat_o,
    output logic [N_SLV-1:0]        s_cyc_o,
    input  logic [N_SLV-1:0]        s_ack_i,
    input  logic [32*N_SLV-1:0]     s_dat_i,
    output logic [32*DBG_REGS-1:0]  dbg_o,
    output logic [7:0]              err_cnt_o
);

    localparam int WORD_W     = SPAN_BITS - 2;
    localparam int IDX_BITS   = clog2(N_SLV);
    localparam int SLV_W      = (IDX_BITS == 0) ? 1 : IDX_BITS;
    localparam int DBG_W      = (clog2(DBG_REGS) == 0) ? 1 : clog2(DBG_REGS);
    localparam int DBG_BASE_I = (1 << WORD_W) - DBG_REGS;
    localparam logic [WORD_W-1:0] DBG_BASE = WORD_W'(DBG_BASE_I);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t            state;
    logic [N_SLV-1:0]  tgt_onehot;
    logic [DBG_W-1:0]  tgt_dbg_idx;
    logic              tgt_unmapped;
    logic [15:0]       tmo_cnt;

    logic [WORD_W-1:0] word_idx;
    logic              dec_dbg;
    logic [DBG_W-1:0]  dec_dbg_idx;
    logic [SLV_W-1:0]  dec_slv_idx;
    logic              dec_mapped;
    logic              sel_ack;
    logic [31:0]       sel_dat;
    logic [31:0]       dbg_rdat;
    logic              dbg_we;
    logic              unused_adr;

    assign unused_adr  = ^{wbs_adr_i[31:SPAN_BITS], wbs_adr_i[1:0]};
    assign word_idx    = wbs_adr_i[SPAN_BITS-1:2];
    assign dec_dbg     = (word_idx >= DBG_BASE);
    assign dec_dbg_idx = DBG_W'(word_idx - DBG_BASE);
    assign dec_mapped  = (32'(dec_slv_idx) < N_SLV);

    generate
        if (IDX_BITS == 0) begin : g_single
            assign dec_slv_idx = '0;
        end else begin : g_multi
            assign dec_slv_idx = wbs_adr_i[SPAN_BITS-1 -: IDX_BITS];
        end
    endgenerate

    // Only the latched target may complete the access; stray acks are masked off.
    always_comb begin
        sel_ack = |(s_ack_i & tgt_onehot);
        sel_dat = '0;
        for (int i = 0; i < N_SLV; i++) begin
            if (tgt_onehot[i]) sel_dat = s_dat_i[32*i +: 32];
        end
    end

    assign dbg_we = (state == ST_DBG) && wbs_cyc_i && wbs_we_i && !tgt_unmapped;

    user_dbg_reg_bank #(
        .DBG_REGS (DBG_REGS),
        .ADDR_W   (DBG_W)
    ) u_dbg_bank (
        .clk    (wb_clk_i),
        .rst    (wb_rst_i),
        .we     (dbg_we),
        .addr   (tgt_dbg_idx),
        .sel    (wbs_sel_i),
        .wdat   (wbs_dat_i),
        .rdat   (dbg_rdat),
        .regs_o (dbg_o)
    );

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state        <= ST_IDLE;
            wbs_ack_o    <= 1'b0;
            wbs_dat_o    <= '0;
            s_cyc_o      <= '0;
            err_cnt_o    <= '0;
            tgt_onehot   <= '0;
            tgt_dbg_idx  <= '0;
            tgt_unmapped <= 1'b0;
            tmo_cnt      <= '0;
        end else begin
            wbs_ack_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // The ack cycle still shows the old stb, so it is not a new request.
                    if (wbs_cyc_i && wbs_stb_i && !wbs_ack_o) begin
                        tmo_cnt     <= '0;
                        tgt_dbg_idx <= dec_dbg_idx;
                        if (dec_dbg) begin
                            tgt_onehot   <= '0;
                            tgt_unmapped <= 1'b0;
                            state        <= ST_DBG;
                        end else if (dec_mapped) begin
                            tgt_onehot   <= N_SLV'(1) << dec_slv_idx;
                            tgt_unmapped <= 1'b0;
                            state        <= ST_SLV;
                        end else begin
                            tgt_onehot   <= '0;
                            tgt_unmapped <= 1'b1;
                            state        <= ST_DBG;
                        end
                    end
                end
                ST_SLV: begin
                    if (!wbs_cyc_i) begin
                        s_cyc_o <= '0;
                        state   <= ST_IDLE;
                    end else if (sel_ack) begin
                        wbs_dat_o <= wbs_we_i ? 32'd0 : sel_dat;
                        s_cyc_o   <= '0;
                        state     <= ST_RESP;
                    end else if ((s_cyc_o != '0) && (tmo_cnt == 16'(TIMEOUT - 1))) begin
                        wbs_dat_o <= ERR_DATA;
                        err_cnt_o <= sat_inc(err_cnt_o);
                        s_cyc_o   <= '0;
                        state     <= ST_RESP;
                    end else begin
                        s_cyc_o <= tgt_onehot;
                        if (s_cyc_o != '0) tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                ST_DBG: begin
                    if (!wbs_cyc_i) begin
                        state <= ST_IDLE;
                    end else begin
                        if (tgt_unmapped) begin
                            wbs_dat_o <= ERR_DATA;
                            err_cnt_o <= sat_inc(err_cnt_o);
                        end else begin
                            wbs_dat_o <= wbs_we_i ? 32'd0 : dbg_rdat;
                        end
                        state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    wbs_ack_o <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_user_wb_window_mux.sv
// Scoreboard bench for user_wb_window_mux (3 slave windows, 2 debug words, TIMEOUT 16).
module tb_user_wb_window_mux;
    import user_wb_window_pkg::*;

    localparam int N_SLV = 3;
    localparam int DBG_REGS = 2;
    localparam int TMO = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic               cyc, stb, we;
    logic [3:0]         sel;
    logic [31:0]        adr, wdat;
    logic               ack;
    logic [31:0]        rdat;
    logic [N_SLV-1:0]   s_cyc, s_ack;
    logic [32*N_SLV-1:0] s_dat;
    logic [32*DBG_REGS-1:0] dbg;
    logic [7:0]         err_cnt;

    int n_chk = 0;
    int n_fail = 0;
    logic [31:0] sb_q [$];
    logic prev_ack = 1'b0;

    int  slv_delay = 0;
    bit  slv_wrong = 1'b0;
    int  cyc_cnt = 0;
    bit  acked = 1'b0;

    always #5 clk = ~clk;

    user_wb_window_mux #(
        .N_SLV(N_SLV), .SPAN_BITS(20), .DBG_REGS(DBG_REGS), .TIMEOUT(TMO)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(wdat),
        .wbs_ack_o(ack), .wbs_dat_o(rdat),
        .s_cyc_o(s_cyc), .s_ack_i(s_ack), .s_dat_i(s_dat),
        .dbg_o(dbg), .err_cnt_o(err_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard: every ack pops one expected read word.
    always @(negedge clk) begin
        if (ack) begin
            chk("ack_single", {31'd0, prev_ack}, 32'd0);
            if (sb_q.size() == 0) chk("sb_extra_ack", 32'd1, 32'd0);
            else chk("rdata", rdat, sb_q.pop_front());
        end
        prev_ack <= ack;
    end

    // Slave model: acks slv_delay cycles after its s_cyc_o rises (0 = never).
    initial begin
        s_ack = '0;
        forever begin
            @(negedge clk);
            s_ack = '0;
            if (s_cyc != '0 && !acked) begin
                cyc_cnt++;
                if (cyc_cnt == slv_delay) begin
                    s_ack = slv_wrong ? ~s_cyc : s_cyc;
                    acked = !slv_wrong;
                end
            end else if (s_cyc == '0) begin
                cyc_cnt = 0;
                acked = 1'b0;
            end
        end
    end

    task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
    endtask

    task automatic release_bus();
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic xfer(input string tag, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [31:0] exp, input int exp_lat,
                        output logic [N_SLV-1:0] scyc_seen);
        int n;
        bit got;
        drive(w, a, d, s);
        sb_q.push_back(exp);
        scyc_seen = '0;
        got = 1'b0;
        n = 0;
        @(posedge clk);
        for (int i = 0; i < 400 && !got; i++) begin
            @(posedge clk); #1;
            n++;
            scyc_seen |= s_cyc;
            if (ack) got = 1'b1;
        end
        chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
        if (!got) void'(sb_q.pop_front());
        @(negedge clk);
        release_bus();
    endtask

    logic [N_SLV-1:0] seen;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cyc = 0; stb = 0; we = 0; sel = 0; adr = 0; wdat = 0;
        s_dat = {32'h3333_0002, 32'hCAFE_0001, 32'h1111_0000};
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", {31'd0, ack}, 32'd0);
        chk("rst_dat", rdat, 32'd0);
        chk("rst_scyc", 32'(s_cyc), 32'd0);
        chk("rst_dbg", dbg[31:0] | dbg[63:32], 32'd0);
        chk("rst_err", 32'(err_cnt), 32'd0);
        chk("rst_state", 32'(dut.state), 32'(ST_IDLE));
        @(negedge clk); rst = 1'b0;

        // Debug bank
        xfer("dbg_wr1", 1, 32'h000F_FFFC, 32'h1234_5678, 4'hF, 32'd0, 2, seen);
        chk("dbg1_val", dbg[63:32], 32'h1234_5678);
        xfer("dbg_rd1", 0, 32'h000F_FFFC, 32'd0, 4'hF, 32'h1234_5678, 2, seen);
        xfer("dbg_wr0", 1, 32'h000F_FFF8, 32'hAABB_CCDD, 4'b0101, 32'd0, 2, seen);
        chk("dbg0_lanes", dbg[31:0], 32'h00BB_00DD);
        xfer("dbg_rd0", 0, 32'h000F_FFF8, 32'd0, 4'hF, 32'h00BB_00DD, 2, seen);
        xfer("dbg_hi_alias", 0, 32'hFFFF_FFFC, 32'd0, 4'hF, 32'h1234_5678, 2, seen);

        // Slave windows
        slv_delay = 3;
        xfer("slv1_rd", 0, 32'h0004_0010, 32'd0, 4'hF, 32'hCAFE_0001, 5, seen);
        chk("slv1_scyc", 32'(seen), 32'b010);
        slv_delay = 1;
        xfer("slv0_wr", 1, 32'h0000_0010, 32'h5555_5555, 4'hF, 32'd0, 3, seen);
        chk("slv0_scyc", 32'(seen), 32'b001);
        slv_delay = 2;
        xfer("slv2_rd", 0, 32'h0008_0000, 32'd0, 4'hF, 32'h3333_0002, 4, seen);
        chk("slv2_scyc", 32'(seen), 32'b100);
        chk("err_after_slv", 32'(err_cnt), 32'd0);

        // Timeouts
        slv_delay = 0;
        xfer("tmo", 0, 32'h0004_0000, 32'd0, 4'hF, ERR_DATA, TMO + 2, seen);
        chk("tmo_err", 32'(err_cnt), 32'd1);
        slv_delay = TMO;
        xfer("tmo_tie", 0, 32'h0004_0000, 32'd0, 4'hF, 32'hCAFE_0001, TMO + 2, seen);
        chk("tie_err", 32'(err_cnt), 32'd1);
        slv_delay = 3; slv_wrong = 1'b1;
        xfer("stray_ack", 0, 32'h0004_0000, 32'd0, 4'hF, ERR_DATA, TMO + 2, seen);
        chk("stray_err", 32'(err_cnt), 32'd2);
        slv_wrong = 1'b0;

        // Unmapped window 3
        xfer("unmap_rd", 0, 32'h000C_0000, 32'd0, 4'hF, ERR_DATA, 2, seen);
        chk("unmap_err", 32'(err_cnt), 32'd3);
        xfer("unmap_wr", 1, 32'h000C_0040, 32'h0, 4'hF, ERR_DATA, 2, seen);
        chk("unmap_err2", 32'(err_cnt), 32'd4);

        // Abort in DBG: no write lands
        drive(1, 32'h000F_FFFC, 32'hFFFF_FFFF, 4'hF);
        @(posedge clk);
        @(negedge clk); release_bus();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("abort_dbg_ack", {31'd0, ack}, 32'd0);
        end
        chk("abort_dbg_val", dbg[63:32], 32'h1234_5678);
        chk("abort_dbg_state", 32'(dut.state), 32'(ST_IDLE));

        // Abort in SLV
        slv_delay = 0;
        drive(0, 32'h0000_0000, 32'd0, 4'hF);
        @(posedge clk);
        repeat (3) @(posedge clk);
        @(negedge clk); release_bus();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("abort_slv_ack", {31'd0, ack}, 32'd0);
        end
        chk("abort_slv_scyc", 32'(s_cyc), 32'd0);
        chk("abort_slv_state", 32'(dut.state), 32'(ST_IDLE));
        chk("abort_slv_err", 32'(err_cnt), 32'd4);
        slv_delay = 2;
        xfer("post_abort", 0, 32'h0008_0004, 32'd0, 4'hF, 32'h3333_0002, 4, seen);

        // Saturation
        for (int i = 0; i < 300; i++)
            xfer("unmap_sat", 0, 32'h000C_0100, 32'd0, 4'hF, ERR_DATA, 2, seen);
        chk("err_sat", 32'(err_cnt), 32'd255);

        // Reset mid-SLV
        slv_delay = 0;
        drive(0, 32'h0004_0000, 32'd0, 4'hF);
        @(posedge clk);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rst_mid_ack", {31'd0, ack}, 32'd0);
        chk("rst_mid_scyc", 32'(s_cyc), 32'd0);
        chk("rst_mid_state", 32'(dut.state), 32'(ST_IDLE));
        chk("rst_mid_err", 32'(err_cnt), 32'd0);
        @(negedge clk); release_bus(); rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk("rst_mid_noack", {31'd0, ack}, 32'd0);
        end
        xfer("post_rst_dbg", 0, 32'h000F_FFFC, 32'd0, 4'hF, 32'd0, 2, seen);
        slv_delay = 2;
        xfer("post_rst_slv", 0, 32'h0004_0000, 32'd0, 4'hF, 32'hCAFE_0001, 4, seen);

        repeat (3) @(posedge clk);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/user_wb_window_mux.md
# user_wb_window_mux

Parametrised Wishbone slave-side window splitter for the user project area: divides the user address span into N_SLV equal windows, forwards each access to one downstream user slave, and answers accesses to the top DBG_REGS words itself from a built-in debug register bank. Unlike the fixed two-way user/debug split, it registers every response, bounds every access with a timeout watchdog, answers unmapped addresses with an error word, and counts failures. It sits between the management SoC Wishbone port and user-project slaves inside the user wrapper.

## Interface
Parameters:
- N_SLV, 2: number of downstream slave windows (1..8).
- SPAN_BITS, 20: user span size in bytes is 2^SPAN_BITS; address bits above SPAN_BITS are ignored.
- DBG_REGS, 2: debug words at the top of the span (1..8).
- TIMEOUT, 255: cycles to wait for s_ack_i before forcing an error response (>=2).

Ports (one clock; reset is asynchronous and active-high):
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  async active-high reset.
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone classic controls.
- wbs_sel_i  in  4  byte lanes.
- wbs_adr_i, wbs_dat_i  in  32 each  address / write data.
- wbs_ack_o  out  1  registered ack, one cycle.
- wbs_dat_o  out  32  registered read data.
- s_cyc_o  out  N_SLV  one-hot cycle strobe to the selected slave; the slaves share wbs_stb_i/we/sel/adr/dat.
- s_ack_i  in  N_SLV  slave acks.
- s_dat_i  in  32*N_SLV  slave read data, slave i at [32i+31:32i].
- dbg_o  out  32*DBG_REGS  live debug register contents.
- err_cnt_o  out  8  saturating count of timeouts plus unmapped accesses.

## Operation
- Decode on adr[SPAN_BITS-1:2]:
  - debug hit when the word index is >= 2^(SPAN_BITS-2) - DBG_REGS; debug has priority over the window decode.
  - otherwise idx = adr[SPAN_BITS-1 -: clog2(N_SLV)]; idx >= N_SLV is unmapped.
  - with N_SLV=1, every non-debug address maps to slave 0.
- FSM states IDLE, SLV, DBG, RESP.
  - IDLE: cyc&stb sampled → latch the target. Slave hit → SLV. Debug or unmapped → DBG.
  - SLV: s_cyc_o[idx] = wbs_cyc_i. The timeout counter increments each cycle from 0. On s_ack_i[idx], capture s_dat_i[idx] → RESP. When the counter reaches TIMEOUT-1, load ERR_DATA = 32'hDEAD_BEEF, increment err_cnt → RESP.
  - DBG: debug write applies wbs_dat_i per byte lane; a debug read captures the register. Unmapped loads ERR_DATA and increments err_cnt. Always → RESP.
  - RESP: wbs_ack_o=1 → IDLE.
- Abort: wbs_cyc_i low in SLV or DBG → IDLE with no ack, no register write, no err increment.
- Simultaneous s_ack_i and timeout on the same edge: the ack wins; no error is recorded.
- s_ack_i from a non-selected slave is ignored.
- err_cnt_o saturates at 255.
- Writes to slaves return wbs_dat_o = 0; unmapped writes return ERR_DATA.

## Timing
- Reset values: state IDLE; wbs_ack_o 0; wbs_dat_o 0; s_cyc_o 0; dbg_o all 0; err_cnt_o 0. Reset mid-access drops the access with no ack.
- Debug/unmapped latency: request sampled at edge k → wbs_ack_o high for the single cycle after edge k+2.
- Slave latency: s_cyc_o high after edge k+1. With s_ack_i sampled at edge m, wbs_ack_o is high for one cycle after edge m+1.
- Timeout: ack asserts TIMEOUT+2 edges after the request edge.
- wbs_ack_o is never high for two consecutive cycles. The master must drop stb in the cycle after ack; a new request is accepted in IDLE on the following edge.
- dbg_o updates on the edge that leaves DBG.

## Structure
- Package user_wb_window_pkg: state enum, ERR_DATA, clog2 function, MAX_SLV=8 and MAX_DBG=8 limits.
- Sub-module user_dbg_reg_bank: DBG_REGS x 32 registers with byte-lane write, combinational read mux, async reset to 0.
- Top contains the decode, FSM, timeout counter, response registers and err counter.

## Test plan
- Debug write 0x1234_5678 (sel=4'hF) to top word, then read back → ack 2 cycles after the request, data 0x1234_5678, dbg_o matches.
- Debug write 0xAABB_CCDD with sel=4'b0101 over value 0 → register = 0x00BB_00DD.
- Read slave 1 (N_SLV=2), slave acks 3 cycles after s_cyc_o with 0xCAFE_0001 → s_cyc_o=2'b10, wbs_dat_o=0xCAFE_0001, single-cycle ack.
- Slave never acks, TIMEOUT=16 → ack with 0xDEAD_BEEF 18 edges after the request, err_cnt_o=1. Second case: ack and timeout on the same edge → slave data returned, err_cnt_o unchanged.
- N_SLV=3, access in window 3 → immediate error response, err_cnt_o increments; 300 such accesses → err_cnt_o holds 255.
- Drop cyc mid-SLV, or assert reset mid-SLV → no ack, s_cyc_o=0, state IDLE; the next access completes normally.
